// File: rtl/vector_exec_unit.sv
// Vector execute stage: lane-wise single-cycle ALU ops plus a lane-serial multiply
// sharing one multiplier, writing results back to the vector register file.
module vector_exec_unit #(
  parameter int regSize     = 8,
  parameter int regQuantity = 4,
  parameter int selBits     = 2,
  parameter int vecSize     = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             inValid,
  output logic                             inReady,
  input  logic [2:0]                       opCode,
  input  logic [vecSize-1:0][regSize-1:0]  srcA,
  input  logic [vecSize-1:0][regSize-1:0]  srcB,
  input  logic [selBits-1:0]               dstReg,
  output logic                             regWrEn,
  output logic [selBits-1:0]               regToWrite,
  output logic [vecSize-1:0][regSize-1:0]  regWriteData,
  output logic                             busy
);

  localparam int CntW = (vecSize > 1) ? $clog2(vecSize) : 1;
  localparam int ShW  = (regSize > 1) ? $clog2(regSize) : 1;

  if ((1 << selBits) < regQuantity) begin : g_sel_check
    $error("selBits too narrow to address regQuantity registers");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_WB   = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef logic [vecSize-1:0][regSize-1:0] vec_t;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  vec_t                 a_q, a_d;
  vec_t                 b_q, b_d;
  vec_t                 res_q, res_d;
  logic [selBits-1:0]   dst_q, dst_d;
  logic                 wr_en_q, wr_en_d;
  logic [selBits-1:0]   wr_addr_q, wr_addr_d;
  vec_t                 wr_data_q, wr_data_d;
  logic                 busy_q, busy_d;

  op_e                  op;
  logic                 accept;
  logic [regSize-1:0]   mul_lane;

  function automatic vec_t alu(input op_e f, input vec_t a, input vec_t b);
    vec_t r;
    r = '0;
    for (int unsigned i = 0; i < vecSize; i++) begin
      case (f)
        OP_ADD:  r[i] = a[i] + b[i];
        OP_SUB:  r[i] = a[i] - b[i];
        OP_AND:  r[i] = a[i] & b[i];
        OP_OR:   r[i] = a[i] | b[i];
        OP_XOR:  r[i] = a[i] ^ b[i];
        OP_SHL:  r[i] = a[i] << b[i][ShW-1:0];
        OP_SHR:  r[i] = a[i] >> b[i][ShW-1:0];
        default: r[i] = '0;
      endcase
    end
    return r;
  endfunction

  assign op       = op_e'(opCode);
  assign inReady  = (state_q == S_IDLE) || (state_q == S_WB);
  assign accept   = inValid && inReady;
  // The one shared multiplier walks captured operands one lane per cycle.
  assign mul_lane = a_q[cnt_q] * b_q[cnt_q];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    dst_d     = dst_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE, S_WB: begin
        state_d = S_IDLE;
        if (accept) begin
          if (op == OP_MUL) begin
            a_d     = srcA;
            b_d     = srcB;
            dst_d   = dstReg;
            cnt_d   = '0;
            state_d = S_MUL;
          end else begin
            wr_data_d = alu(op, srcA, srcB);
            wr_addr_d = dstReg;
            wr_en_d   = 1'b1;
            state_d   = S_WB;
          end
        end
      end
      S_MUL: begin
        res_d[cnt_q] = mul_lane;
        cnt_d        = cnt_q + CntW'(1);
        if (cnt_q == CntW'(vecSize - 1)) begin
          wr_data_d = res_d;
          wr_addr_d = dst_q;
          wr_en_d   = 1'b1;
          state_d   = S_WB;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_MUL);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      dst_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      dst_q     <= dst_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign regWrEn      = wr_en_q;
  assign regToWrite   = wr_addr_q;
  assign regWriteData = wr_data_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vector_exec_unit.sv
// Directed bench for vector_exec_unit: streamed ALU vector table, multi-cycle
// multiply, reset abort and write-back into a behavioural register file.
module tb_vector_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [2:0]  opCode;
  logic [31:0] srcA, srcB;
  logic [1:0]  dstReg;
  logic        regWrEn;
  logic [1:0]  regToWrite;
  logic [31:0] regWriteData;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf [4];

  vector_exec_unit #(
    .regSize    (8),
    .regQuantity(4),
    .selBits    (2),
    .vecSize    (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .inValid     (inValid),
    .inReady     (inReady),
    .opCode      (opCode),
    .srcA        (srcA),
    .srcB        (srcB),
    .dstReg      (dstReg),
    .regWrEn     (regWrEn),
    .regToWrite  (regToWrite),
    .regWriteData(regWriteData),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (regWrEn) rf[regToWrite] <= regWriteData;
  end

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  dst;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] d);
    inValid = v;
    opCode  = op;
    srcA    = a;
    srcB    = b;
    dstReg  = d;
  endtask

  initial begin
    logic        saw_wr;
    logic [31:0] word;
    logic [3:0][7:0] lanes;

    tbl[0] = '{"add",      3'b000, 32'h01020304, 32'h10203040, 2'd2, 32'h11223344};
    tbl[1] = '{"sub_wrap", 3'b001, 32'h00000005, 32'h00000106, 2'd1, 32'h0000FFFF};
    tbl[2] = '{"xor",      3'b100, 32'hFF00FF00, 32'h0F0F0F0F, 2'd3, 32'hF00FF00F};
    tbl[3] = '{"shl_mod",  3'b101, 32'h01010101, 32'h00010709, 2'd0, 32'h01028002};
    tbl[4] = '{"and",      3'b010, 32'hF0F0AA55, 32'hFF0F5AA5, 2'd1, 32'hF0000A05};
    tbl[5] = '{"or",       3'b011, 32'h12340000, 32'h00005678, 2'd2, 32'h12345678};
    tbl[6] = '{"shr_mod",  3'b110, 32'h80FF8001, 32'h07040F01, 2'd0, 32'h010F0100};
    tbl[7] = '{"add_wrap", 3'b000, 32'hFFFF80FF, 32'h01010180, 2'd3, 32'h0000817F};

    drive(1'b0, 3'b000, 32'h0, 32'h0, 2'd0);
    reset = 1'b0;
    step();
    chk("rst_wren",  {31'b0, regWrEn}, 32'd0);
    chk("rst_addr",  {30'b0, regToWrite}, 32'd0);
    chk("rst_data",  regWriteData, 32'h0);
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_ready", {31'b0, inReady}, 32'd1);
    reset = 1'b1;
    step();

    // Streamed ALU table: each op is accepted while the previous one is in WB.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dst);
      chk({tbl[i].name, "_ready"}, {31'b0, inReady}, 32'd1);
      step();
      chk({tbl[i].name, "_wren"}, {31'b0, regWrEn}, 32'd1);
      chk({tbl[i].name, "_addr"}, {30'b0, regToWrite}, {30'b0, tbl[i].dst});
      chk({tbl[i].name, "_data"}, regWriteData, tbl[i].exp);
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0, 2'd0);
    step();
    chk("alu_idle_wren", {31'b0, regWrEn}, 32'd0);
    chk("alu_idle_hold", regWriteData, 32'h0000817F);

    // Multiply: operands changed and a stray op pulsed while busy.
    drive(1'b1, 3'b111, 32'h02031011, 32'h03041011, 2'd3);
    step();
    drive(1'b0, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mul_busy%0d", k),  {31'b0, busy}, 32'd1);
      chk($sformatf("mul_ready%0d", k), {31'b0, inReady}, 32'd0);
      chk($sformatf("mul_wren%0d", k),  {31'b0, regWrEn}, 32'd0);
      inValid = (k == 1);
      step();
    end
    inValid = 1'b0;
    chk("mul_wb_wren", {31'b0, regWrEn}, 32'd1);
    chk("mul_wb_addr", {30'b0, regToWrite}, 32'd3);
    chk("mul_wb_data", regWriteData, 32'h060C0021);
    chk("mul_wb_busy", {31'b0, busy}, 32'd0);
    step();
    chk("mul_after_wren", {31'b0, regWrEn}, 32'd0);
    chk("mul_after_hold", regWriteData, 32'h060C0021);

    // Reset on the second busy cycle aborts the multiply.
    drive(1'b1, 3'b111, 32'h05050505, 32'h03030303, 2'd2);
    step();
    inValid = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("abort_wren",  {31'b0, regWrEn}, 32'd0);
    chk("abort_addr",  {30'b0, regToWrite}, 32'd0);
    chk("abort_data",  regWriteData, 32'h0);
    chk("abort_busy",  {31'b0, busy}, 32'd0);
    chk("abort_ready", {31'b0, inReady}, 32'd1);
    reset = 1'b1;
    saw_wr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (regWrEn) saw_wr = 1'b1;
    end
    chk("abort_no_write", {31'b0, saw_wr}, 32'd0);

    // Write-back into the register file model, then read lanes back.
    drive(1'b1, 3'b011, 32'hDEADBEEF, 32'h00000000, 2'd1);
    step();
    inValid = 1'b0;
    step();
    word  = rf[1];
    lanes = word;
    chk("rf_lane3", {24'b0, lanes[3]}, 32'h000000DE);
    chk("rf_lane2", {24'b0, lanes[2]}, 32'h000000AD);
    chk("rf_lane1", {24'b0, lanes[1]}, 32'h000000BE);
    chk("rf_lane0", {24'b0, lanes[0]}, 32'h000000EF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
